// File: rtl/analyzer_settings_ctrl.sv
// Front-panel settings controller for a logic analyzer: debounced buttons with
// auto-repeat drive timebase preset, channel selection and per-channel trigger kinds.
module analyzer_settings_ctrl #(
    parameter int CHANNELS        = 16,
    parameter int N_PRESETS       = 32,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int LONG_PRESS      = 100000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          faster,
    input  logic                          slower,
    input  logic                          chan_next,
    input  logic                          chan_prev,
    input  logic                          trig_toggle,
    output logic [$clog2(N_PRESETS)-1:0]  PRESET_INDEX,
    output logic [$clog2(CHANNELS)-1:0]   CURRENT_CHANNEL,
    output logic [2*CHANNELS-1:0]         TRIGGER_KIND,
    output logic                          SETTINGS_CHANGED
);
    localparam int PW   = $clog2(N_PRESETS);
    localparam int CW   = $clog2(CHANNELS);
    localparam int NB   = 5;
    localparam int NR   = 4;
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam int HW   = $clog2(LONG_PRESS + 1);

    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RPT_FIRST  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RPT_NEXT   = RW'(REPEAT_PERIOD);
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(LONG_PRESS);
    localparam logic [PW-1:0] PRESET_MAX = PW'(N_PRESETS - 1);
    localparam logic [CW-1:0] CHAN_MAX   = CW'(CHANNELS - 1);

    typedef enum logic [1:0] {IDLE, HELD, CLEARED} trig_state_t;

    // bit order: 0 faster, 1 slower, 2 chan_next, 3 chan_prev, 4 trig_toggle
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] sync_p0, sync_p1;
    logic [NB-1:0] acc_p2, acc_p3;
    logic [DW-1:0] db_cnt [NB];
    logic [NB-1:0] press;
    logic [RW-1:0] rpt_cnt [NR];
    logic [NR-1:0] rpt_started;
    logic [NR-1:0] rpt_evt;
    logic [NR-1:0] ev;

    trig_state_t   state, state_nxt;
    logic [HW-1:0] hold_cnt;
    logic          hold_clr, hold_inc, toggle_evt, clear_evt;

    logic [PW-1:0]         preset_nxt;
    logic [CW-1:0]         chan_nxt;
    logic [2*CHANNELS-1:0] kind_nxt;

    assign btn_raw = {trig_toggle, chan_prev, chan_next, slower, faster};

    // Synchroniser and debouncer: idle level is 1 (released)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
            acc_p2  <= '1;
            acc_p3  <= '1;
            for (int b = 0; b < NB; b++) db_cnt[b] <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
            acc_p3  <= acc_p2;
            for (int b = 0; b < NB; b++) begin
                if (sync_p1[b] == acc_p2[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == DB_LAST) begin
                    acc_p2[b] <= sync_p1[b];
                    db_cnt[b] <= '0;
                end else begin
                    db_cnt[b] <= db_cnt[b] + 1'b1;
                end
            end
        end
    end

    assign press = acc_p3 & ~acc_p2;

    // Auto-repeat: counter is 0 on the press cycle, so the first repeat lands REPEAT_DELAY later
    always_comb begin
        for (int b = 0; b < NR; b++) begin
            rpt_evt[b] = ~acc_p2[b] & (rpt_started[b] ? (rpt_cnt[b] == RPT_NEXT)
                                                      : (rpt_cnt[b] == RPT_FIRST));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_started <= '0;
            for (int b = 0; b < NR; b++) rpt_cnt[b] <= '0;
        end else begin
            for (int b = 0; b < NR; b++) begin
                if (acc_p2[b]) begin
                    rpt_cnt[b]     <= '0;
                    rpt_started[b] <= 1'b0;
                end else if (rpt_evt[b]) begin
                    rpt_cnt[b]     <= RW'(1);
                    rpt_started[b] <= 1'b1;
                end else begin
                    rpt_cnt[b] <= rpt_cnt[b] + 1'b1;
                end
            end
        end
    end

    assign ev = press[NR-1:0] | rpt_evt;

    // Trigger toggle: short press toggles on release, long hold clears every channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (hold_clr)      hold_cnt <= '0;
            else if (hold_inc) hold_cnt <= hold_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        hold_clr   = 1'b0;
        hold_inc   = 1'b0;
        toggle_evt = 1'b0;
        clear_evt  = 1'b0;
        case (state)
            IDLE: begin
                if (press[4]) begin
                    state_nxt = HELD;
                    hold_clr  = 1'b1;
                end
            end
            HELD: begin
                if (acc_p2[4]) begin
                    state_nxt  = IDLE;
                    toggle_evt = 1'b1;
                end else if (hold_cnt == HOLD_LIMIT) begin
                    state_nxt = CLEARED;
                    clear_evt = 1'b1;
                end else begin
                    hold_inc = 1'b1;
                end
            end
            CLEARED: begin
                if (acc_p2[4]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Settings update; toggle uses the channel selected before any change this cycle
    always_comb begin
        preset_nxt = PRESET_INDEX;
        if (ev[0]) begin
            if (PRESET_INDEX != PRESET_MAX) preset_nxt = PRESET_INDEX + 1'b1;
        end else if (ev[1]) begin
            if (PRESET_INDEX != '0) preset_nxt = PRESET_INDEX - 1'b1;
        end

        chan_nxt = CURRENT_CHANNEL;
        if (ev[2])      chan_nxt = (CURRENT_CHANNEL == CHAN_MAX) ? '0 : CURRENT_CHANNEL + 1'b1;
        else if (ev[3]) chan_nxt = (CURRENT_CHANNEL == '0) ? CHAN_MAX : CURRENT_CHANNEL - 1'b1;

        kind_nxt = TRIGGER_KIND;
        if (clear_evt) begin
            kind_nxt = '0;
        end else if (toggle_evt) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (CW'(c) == CURRENT_CHANNEL) kind_nxt[2*c +: 2] = TRIGGER_KIND[2*c +: 2] + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PRESET_INDEX     <= '0;
            CURRENT_CHANNEL  <= '0;
            TRIGGER_KIND     <= '0;
            SETTINGS_CHANGED <= 1'b0;
        end else begin
            PRESET_INDEX     <= preset_nxt;
            CURRENT_CHANNEL  <= chan_nxt;
            TRIGGER_KIND     <= kind_nxt;
            SETTINGS_CHANGED <= (preset_nxt != PRESET_INDEX) || (chan_nxt != CURRENT_CHANNEL) ||
                                (kind_nxt != TRIGGER_KIND);
        end
    end
endmodule
